// File: rtl/rr_sel_scheduler.sv
// Round-robin scheduler sharing one 3-to-8 select decoder among six requesters.
// Grants are time-sliced and always separated by one dead cycle.
module rr_sel_scheduler #(
  parameter int unsigned SLICE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] req,
  output logic [2:0] sel,
  output logic [5:0] grant,
  output logic       valid,
  output logic       last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(SLICE - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] sel_q, sel_d;
  logic [5:0] grant_q, grant_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic [2:0] win;

  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i == 3'd5) ? 3'd0 : i + 3'd1;
  endfunction

  // Rotating search from ptr; ptr is always 0-5 so only six positions are visited.
  always_comb begin
    logic [2:0] idx;
    logic       found;
    win   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < 6; k++) begin
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
      idx = next_idx(idx);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    last_d  = last_q;
    grant_d = '0;

    unique case (state_q)
      IDLE, GAP: begin
        cnt_d   = '0;
        sel_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = IDLE;
        if (req != '0) begin
          state_d = GRANT;
          sel_d   = win;
          valid_d = 1'b1;
          last_d  = (SLICE == 1);
        end
      end
      GRANT: begin
        if (!req[sel_q] || cnt_q == CNT_MAX) begin
          state_d = GAP;
          ptr_d   = next_idx(sel_q);
          sel_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q + 8'd1;
          last_d = (cnt_q + 8'd1 == CNT_MAX);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sel_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    if (valid_d) grant_d[sel_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign valid = valid_q;
  assign last  = last_q;

endmodule

// File: tb/tb_rr_sel_scheduler.sv
// Bench for rr_sel_scheduler: three instances (SLICE=4,2,1) against a cycle model
// with a scoreboard queue, a hand-derived vector table, and invariant checks.
module tb_rr_sel_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] req;
  logic [2:0] sel_w   [3];
  logic [5:0] grant_w [3];
  logic       valid_w [3];
  logic       last_w  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_sel_scheduler #(.SLICE(4)) u_s4 (.clk(clk), .rst_n(rst_n), .req(req),
    .sel(sel_w[0]), .grant(grant_w[0]), .valid(valid_w[0]), .last(last_w[0]));
  rr_sel_scheduler #(.SLICE(2)) u_s2 (.clk(clk), .rst_n(rst_n), .req(req),
    .sel(sel_w[1]), .grant(grant_w[1]), .valid(valid_w[1]), .last(last_w[1]));
  rr_sel_scheduler #(.SLICE(1)) u_s1 (.clk(clk), .rst_n(rst_n), .req(req),
    .sel(sel_w[2]), .grant(grant_w[2]), .valid(valid_w[2]), .last(last_w[2]));

  int slice_of [3] = '{4, 2, 1};

  typedef struct {
    int st;   // 0 idle, 1 grant, 2 gap
    int ptr;
    int cnt;
    int sel;
    bit valid;
    bit last;
  } mdl_t;
  mdl_t m [3];

  typedef struct {
    int         k;
    logic [10:0] exp;
  } sb_t;
  sb_t sb_q [$];

  typedef struct {
    logic [5:0] req;
    logic [2:0] sel;
    bit         valid;
    bit         last;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int arb(input logic [5:0] r, input int p);
    for (int j = 0; j < 6; j++) begin
      if (r[(p + j) % 6]) return (p + j) % 6;
    end
    return 0;
  endfunction

  function automatic void mreset(input int k);
    m[k] = '{0, 0, 0, 0, 1'b0, 1'b0};
  endfunction

  function automatic void mstep(input int k, input logic [5:0] r);
    int s;
    s = slice_of[k];
    if (m[k].st == 1) begin
      if (!r[m[k].sel] || m[k].cnt == s - 1) begin
        m[k].st = 2;
        m[k].ptr = (m[k].sel + 1) % 6;
        m[k].sel = 0; m[k].valid = 0; m[k].last = 0;
      end else begin
        m[k].cnt++;
        m[k].last = (m[k].cnt == s - 1);
      end
    end else if (r != 0) begin
      m[k].st = 1;
      m[k].sel = arb(r, m[k].ptr);
      m[k].cnt = 0; m[k].valid = 1; m[k].last = (s == 1);
    end else begin
      m[k].st = 0;
      m[k].sel = 0; m[k].valid = 0; m[k].last = 0; m[k].cnt = 0;
    end
  endfunction

  function automatic logic [10:0] mpack(input int k);
    logic [5:0] g;
    g = '0;
    if (m[k].valid) g[m[k].sel] = 1'b1;
    return {3'(m[k].sel), g, m[k].valid, m[k].last};
  endfunction

  function automatic logic [10:0] dpack(input int k);
    return {sel_w[k], grant_w[k], valid_w[k], last_w[k]};
  endfunction

  // One clock: model advances with the current req, DUT samples at the edge.
  task automatic cyc();
    sb_t e;
    for (int k = 0; k < 3; k++) begin
      mstep(k, req);
      sb_q.push_back('{k, mpack(k)});
    end
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("sb_s%0d", slice_of[e.k]), 32'(dpack(e.k)), 32'(e.exp));
    end
  endtask

  task automatic run(input logic [5:0] r, input int n);
    req = r;
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Invariants, sampled on the falling edge.
  int  run_len   [3] = '{0, 0, 0};
  bit  prev_v    [3] = '{0, 0, 0};
  logic [2:0] prev_s [3];
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [5:0] exp_g;
      exp_g = '0;
      if (valid_w[k] && sel_w[k] < 3'd6) exp_g[sel_w[k]] = 1'b1;
      check($sformatf("inv_sel_range_s%0d", slice_of[k]), 32'(sel_w[k] < 3'd6), 32'd1);
      check($sformatf("inv_onehot0_s%0d", slice_of[k]), 32'($onehot0(grant_w[k])), 32'd1);
      check($sformatf("inv_grant_decode_s%0d", slice_of[k]), 32'(grant_w[k]), 32'(exp_g));
      if (valid_w[k]) run_len[k]++; else run_len[k] = 0;
      check($sformatf("inv_run_len_s%0d", slice_of[k]), 32'(run_len[k] <= slice_of[k]), 32'd1);
      if (prev_v[k] && valid_w[k])
        check($sformatf("inv_no_gapless_switch_s%0d", slice_of[k]), 32'(sel_w[k]), 32'(prev_s[k]));
      prev_v[k] = valid_w[k];
      prev_s[k] = sel_w[k];
    end
  end

  initial begin
    // SLICE=1 after reset: 0,gap,1,gap,0,gap then back to idle.
    tbl[0] = '{6'b000011, 3'd0, 1'b1, 1'b1};
    tbl[1] = '{6'b000011, 3'd0, 1'b0, 1'b0};
    tbl[2] = '{6'b000011, 3'd1, 1'b1, 1'b1};
    tbl[3] = '{6'b000011, 3'd0, 1'b0, 1'b0};
    tbl[4] = '{6'b000011, 3'd0, 1'b1, 1'b1};
    tbl[5] = '{6'b000011, 3'd0, 1'b0, 1'b0};
    tbl[6] = '{6'b000000, 3'd0, 1'b0, 1'b0};
    tbl[7] = '{6'b000000, 3'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    req   = 6'b111111;
    for (int k = 0; k < 3; k++) mreset(k);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("reset_outputs_s%0d", slice_of[k]), 32'(dpack(k)), 32'd0);
    req   = '0;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req;
      cyc();
      check($sformatf("tbl_s1_row%0d", i), 32'({sel_w[2], valid_w[2], last_w[2]}),
            32'({tbl[i].sel, tbl[i].valid, tbl[i].last}));
      check($sformatf("tbl_s1_grant_row%0d", i), 32'(grant_w[2]),
            32'(tbl[i].valid ? (6'd1 << tbl[i].sel) : 6'd0));
    end

    // Single requester: 4-on/1-off pattern on the SLICE=4 instance.
    req = 6'b000100;
    cyc();
    check("single_first_grant", 32'({sel_w[0], grant_w[0], valid_w[0]}), 32'({3'd2, 6'b000100, 1'b1}));
    run(6'b000100, 2);
    cyc();
    check("single_last_4th", 32'({valid_w[0], last_w[0]}), 32'b11);
    cyc();
    check("single_gap", 32'(valid_w[0]), 32'd0);
    cyc();
    check("single_regrant", 32'({sel_w[0], valid_w[0]}), 32'({3'd2, 1'b1}));
    run(6'b000100, 10);
    run(6'b000000, 3);

    // All requesting: round-robin rotation with wrap.
    run(6'b111111, 30);
    run(6'b000000, 3);

    // Early release with requester 5 pending.
    run(6'b000001, 2);
    req = 6'b100000;
    cyc();
    check("early_release_drop", 32'(valid_w[0]), 32'd0);
    cyc();
    check("early_release_next", 32'({sel_w[0], grant_w[0]}), 32'({3'd5, 6'b100000}));
    run(6'b000000, 6);

    // Fairness after wrap: serve 4, then 5 ranks first, then 0.
    run(6'b010000, 1);
    req = 6'b100001;
    cyc();
    cyc();
    check("wrap_grant5", 32'({sel_w[0], valid_w[0]}), 32'({3'd5, 1'b1}));
    run(6'b100001, 5);
    check("wrap_then0", 32'({sel_w[0], valid_w[0]}), 32'({3'd0, 1'b1}));
    run(6'b100001, 12);
    run(6'b000000, 5);

    // Async reset mid-grant.
    req = 6'b001000;
    cyc();
    check("pre_reset_sel3", 32'({sel_w[0], valid_w[0]}), 32'({3'd3, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("async_reset_s%0d", slice_of[k]), 32'(dpack(k)), 32'd0);
      mreset(k);
    end
    @(posedge clk);
    #1;
    check("reset_held_s4", 32'(dpack(0)), 32'd0);
    rst_n = 1'b1;
    cyc();
    check("post_reset_sel3", 32'({sel_w[0], grant_w[0], valid_w[0]}), 32'({3'd3, 6'b001000, 1'b1}));
    run(6'b001000, 6);
    run(6'b101010, 12);
    run(6'b000000, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
